// File: rtl/add_int32_reduce.sv
// ---------------------------------------------------------------------------
// add_int32_reduce
//   Sequential reduction stage. It accepts a stream of LEN 32-bit
//   two's-complement words and folds them into one running sum using a single
//   combinational add_int32 core. It returns the wrapped sum and a sticky
//   signed-overflow flag over an output valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a reduction (sampled only in IDLE)
//   len        element count, sampled with start (0 .. 2^CNT_W-1)
//   in_valid   upstream word valid
//   in_ready   block accepts a word (high only while accumulating)
//   in_data    operand word
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum modulo 2^32
//   out_ovf    sticky signed overflow seen during the reduction
//   busy       high whenever the block is not idle
// ---------------------------------------------------------------------------

// Combinational 32-bit adder with signed-overflow detection.
module add_int32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o,
  output logic        ovf_o
);
  assign sum_o = a_i + b_i;
  // Overflow happens only when both operands share a sign and the result flips it.
  assign ovf_o = (a_i[31] == b_i[31]) && (sum_o[31] != a_i[31]);
endmodule

module add_int32_reduce #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  // Result registers are separate from the accumulator so the published
  // result holds its value while the next reduction is in progress.
  logic [31:0]      sum_out_q, sum_out_d;
  logic             ovf_out_q, ovf_out_d;

  logic [31:0]      add_sum;
  logic             add_ovf;

  add_int32 u_add (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    sum_out_d = sum_out_q;
    ovf_out_d = ovf_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          if (len != '0) begin
            len_d   = len;
            state_d = S_ACC;
          end else begin
            // Empty reduction: publish a zero result immediately.
            sum_out_d = '0;
            ovf_out_d = 1'b0;
            state_d   = S_OUT;
          end
        end
      end

      S_ACC: begin
        if (in_valid) begin
          acc_d   = add_sum;
          // count_q < len_q here, so the increment can never wrap.
          count_d = count_q + 1'b1;
          ovf_d   = ovf_q | add_ovf;
          if (count_d == len_q) begin
            sum_out_d = add_sum;
            ovf_out_d = ovf_q | add_ovf;
            state_d   = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      sum_out_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      sum_out_q <= sum_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = sum_out_q;
  assign out_ovf   = ovf_out_q;

endmodule

// File: tb/tb_add_int32_reduce.sv
// Testbench for add_int32_reduce: directed cases from the test plan plus
// randomized reductions, checked every cycle against a behavioural model.
module tb_add_int32_reduce;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_sum;
  logic             out_ovf;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  add_int32_reduce #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting words, 2 result offered
  int          m_phase = 0;
  int          m_len   = 0;
  logic [31:0] m_sum   = '0;
  logic        m_ovf   = 1'b0;
  logic [31:0] m_words[$];

  always @(posedge clk or posedge rst) begin
    longint s, t;
    bit     o;
    if (rst) begin
      m_phase = 0;
      m_sum   = '0;
      m_ovf   = 1'b0;
      m_words.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
          m_len = int'(len_in);
          m_words.delete();
          if (m_len == 0) begin
            m_sum   = '0;
            m_ovf   = 1'b0;
            m_phase = 2;
          end else begin
            m_phase = 1;
          end
        end
        1: if (in_valid) begin
          m_words.push_back(in_data);
          if (m_words.size() == m_len) begin
            // Exact 64-bit running sum of wrapped partial sums; any step
            // leaving the int32 range is a signed overflow.
            s = 0;
            o = 1'b0;
            foreach (m_words[i]) begin
              t = s + longint'($signed(m_words[i]));
              if (t > 64'sd2147483647 || t < -64'sd2147483648) o = 1'b1;
              s = longint'($signed(t[31:0]));
            end
            m_sum   = s[31:0];
            m_ovf   = o;
            m_phase = 2;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready",  {31'd0, in_ready},  {31'd0, m_phase == 1});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
    chk("busy",      {31'd0, busy},      {31'd0, m_phase != 0});
    chk("out_sum",   out_sum,            m_sum);
    chk("out_ovf",   {31'd0, out_ovf},   {31'd0, m_ovf});
  end

  // ---------------- stimulus ----------------
  logic [31:0] words [0:255];

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_word;
    case ($urandom % 4)
      0:       return 32'h7FFF_FFFF - ($urandom % 16);
      1:       return 32'h8000_0000 + ($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  // valid_mode: 0 always valid, 1 random, 2 pattern 1,0,0,1 repeating
  task automatic run_reduce(input int n, input int valid_mode, input int ready_delay,
                            input bit pulse_start, input bit lit,
                            input logic [31:0] lit_sum, input logic lit_ovf);
    int i, guard, cyc;
    bit take;
    start  = 1'b1;
    len_in = n[CNT_W-1:0];
    tick();
    start  = 1'b0;
    len_in = CNT_W'($urandom);
    i = 0; guard = 0; cyc = 0;
    while (i < n && guard < 5000) begin
      case (valid_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = 1'($urandom % 2);
        default: in_valid = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      in_data = in_valid ? words[i] : $urandom;
      #1;
      take = in_valid && in_ready;
      tick();
      if (take) i++;
      cyc++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL beats_timeout: accepted %0d required %0d", i, n);
    end
    // Result must be offered in the cycle right after the last beat.
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < ready_delay; k++) begin
      start  = pulse_start;
      len_in = CNT_W'($urandom % 4);
      if (lit) begin
        chk("held_sum", out_sum, lit_sum);
        chk("held_ovf", {31'd0, out_ovf}, {31'd0, lit_ovf});
      end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL out_timeout: out_valid 0 required 1");
    end
    if (lit) begin
      chk("lit_sum", out_sum, lit_sum);
      chk("lit_ovf", {31'd0, out_ovf}, {31'd0, lit_ovf});
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_out_sum",   out_sum,            32'd0);
    chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    #1;
    rst = 1'b0;
    tick();

    // 1,2,3,4
    words[0] = 1; words[1] = 2; words[2] = 3; words[3] = 4;
    run_reduce(4, 0, 0, 1'b0, 1'b1, 32'd10, 1'b0);
    // sticky overflow
    words[0] = 32'h7FFF_FFFF; words[1] = 1; words[2] = 32'hFFFF_FFFF;
    run_reduce(3, 0, 0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
    // valid toggling 1,0,0,1
    words[0] = 32'hFFFF_FFFF; words[1] = 1;
    run_reduce(2, 2, 0, 1'b0, 1'b1, 32'd0, 1'b0);
    // empty reduction
    run_reduce(0, 0, 0, 1'b0, 1'b1, 32'd0, 1'b0);
    // back-pressure with ignored start pulses
    words[0] = 5; words[1] = 6;
    run_reduce(2, 0, 3, 1'b1, 1'b1, 32'd11, 1'b0);
    words[0] = 7;
    run_reduce(1, 0, 0, 1'b0, 1'b1, 32'd7, 1'b0);

    // reset in the middle of a reduction
    start = 1'b1; len_in = 5; tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h7000_0000; tick();
    in_data = 32'h7000_0000; tick();
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy",      {31'd0, busy},      32'd0);
    chk("arst_out_sum",   out_sum,            32'd0);
    chk("arst_out_ovf",   {31'd0, out_ovf},   32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    words[0] = 9;
    run_reduce(1, 0, 0, 1'b0, 1'b1, 32'd9, 1'b0);

    // randomized reductions
    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom % 21);
      for (int j = 0; j < n; j++) words[j] = rand_word();
      run_reduce(n, 1, int'($urandom % 4), 1'($urandom % 2), 1'b0, 32'd0, 1'b0);
      if ($urandom % 2) tick();
    end

    // maximum length
    for (int j = 0; j < 255; j++) words[j] = rand_word();
    run_reduce(255, 1, 1, 1'b0, 1'b0, 32'd0, 1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
